// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared matrix-multiplier beat widths and split FSM state type
package mm_pkg;

    // Shared with the operand-side concatenator so both ends agree on RATIO.
    localparam int MM_WIDE_WIDTH = 512;
    localparam int MM_BEAT_WIDTH = 256;
    localparam int MM_BEAT_RATIO = MM_WIDE_WIDTH / MM_BEAT_WIDTH;

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } split_state_t;

endpackage

// File: rtl/c_data_split.sv
// rtl/c_data_split.sv - wide-to-narrow width down-converter, LS slice first
module c_data_split
    import mm_pkg::*;
#(
    parameter int DATA_INPUT_WIDTH  = MM_WIDE_WIDTH,
    parameter int DATA_OUTPUT_WIDTH = MM_BEAT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid_i,
    input  logic [DATA_INPUT_WIDTH-1:0]  data_i,
    output logic                         accepted,
    output logic [DATA_OUTPUT_WIDTH-1:0] data_o,
    output logic                         valid_o,
    output logic                         last_o,
    input  logic                         ready_i
);

    localparam int RATIO = DATA_INPUT_WIDTH / DATA_OUTPUT_WIDTH;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(RATIO - 2);

    generate
        if (RATIO < 2 || RATIO * DATA_OUTPUT_WIDTH != DATA_INPUT_WIDTH) begin : g_ratio_check
            $error("c_data_split: DATA_INPUT_WIDTH must be an integer multiple >= 2 of DATA_OUTPUT_WIDTH");
        end
    endgenerate

    split_state_t                state_q;
    split_state_t                state_d;
    logic [DATA_INPUT_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]            cnt;
    logic                        last_q;
    logic                        beat_take;
    logic                        last_take;
    logic                        load;

    assign valid_o   = (state_q == BUSY);
    assign last_o    = last_q;
    assign data_o    = shreg[DATA_OUTPUT_WIDTH-1:0];
    assign beat_take = valid_o & ready_i;
    assign last_take = beat_take & (cnt == CNT_LAST);
    // accepted never looks at valid_i, so upstream cannot form a comb loop through it.
    assign accepted  = (state_q == EMPTY) | last_take;
    assign load      = valid_i & accepted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = BUSY;
        end else if (last_take) begin
            state_d = EMPTY;
        end
    end

    // Load takes priority over drain so back-to-back words stream with no bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg  <= '0;
            cnt    <= '0;
            last_q <= 1'b0;
        end else if (load) begin
            shreg  <= data_i;
            cnt    <= '0;
            last_q <= 1'b0;
        end else if (last_take) begin
            last_q <= 1'b0;
        end else if (beat_take) begin
            shreg  <= shreg >> DATA_OUTPUT_WIDTH;
            cnt    <= cnt + CNT_W'(1);
            last_q <= (cnt == CNT_PENULT);
        end
    end

endmodule
